// File: rtl/cpu_pkg.sv
// Shared definitions for the R/I/J pipelined CPU.
//   DATA_W / REG_ADDR_W : datapath and register-file address widths
//   OP_*                : primary opcodes (IR[31:26])
//   *_HI / *_LO         : IR field bit positions
//   addr_sel_e / data_sel_e : write-back mux selects produced by wb_decode
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // All ALU-immediate opcodes share the 001xxx prefix.
  localparam logic [2:0] OP_IMM_CLASS = 3'b001;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;

  typedef enum logic {ASEL_RT = 1'b0, ASEL_RD = 1'b1} addr_sel_e;
  typedef enum logic {DSEL_ALU = 1'b0, DSEL_LMD = 1'b1} data_sel_e;

endpackage

// File: rtl/wb_decode.sv
// Write-back decode: classifies the registered instruction word.
//   ir_i        : instruction word (IR field layout assumes 32 bits)
//   write_o     : instruction writes the register file
//   addr_sel_o  : destination field select (ASEL_RT / ASEL_RD)
//   data_sel_o  : write data select (DSEL_ALU / DSEL_LMD)
module wb_decode
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] ir_i,
  output logic              write_o,
  output logic              addr_sel_o,
  output logic              data_sel_o
);

  logic [5:0] opc;
  assign opc = ir_i[OPC_HI:OPC_LO];

  always_comb begin
    write_o    = 1'b0;
    addr_sel_o = ASEL_RT;
    data_sel_o = DSEL_ALU;
    case (opc)
      OP_RTYPE: begin
        // All-zero word is the NOP bubble, not an sll r0.
        if (ir_i != '0) begin
          write_o    = 1'b1;
          addr_sel_o = ASEL_RD;
        end
      end
      OP_ADDI, OP_ANDI: write_o = 1'b1;
      OP_LW: begin
        write_o    = 1'b1;
        data_sel_o = DSEL_LMD;
      end
      OP_SW, OP_BEQ, OP_BNE, OP_J: write_o = 1'b0;
      default: begin
        // Remaining 001xxx immediates; every other opcode has no write.
        if (opc[5:3] == OP_IMM_CLASS) write_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_seg.sv
// Write-back stage: registers the MEM/WB values and drives the register
// file write port combinationally from those registers (1-cycle latency).
//   clk, rst      : clock, asynchronous active-low reset
//   LMD_i, ALUo_i : load data / ALU result from MEM
//   cond_i        : branch condition from MEM (registered, never observed)
//   IR_i          : instruction word from MEM
//   WB_Write/WB_Addr/WB_Data : register-file write port; addr/data are
//                   zero whenever no write is issued.
// Optional: define WB_R0_GUARD_EN to suppress writes whose destination is r0.
module wb_seg
#(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     LMD_i,
  input  logic [DATA_W-1:0]     ALUo_i,
  input  logic [DATA_W-1:0]     cond_i,
  input  logic [DATA_W-1:0]     IR_i,
  output logic [DATA_W-1:0]     WB_Data,
  output logic                  WB_Write,
  output logic [REG_ADDR_W-1:0] WB_Addr
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] LMD_q, ALUo_q, cond_q, IR_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LMD_q  <= '0;
      ALUo_q <= '0;
      cond_q <= '0;
      IR_q   <= '0;
    end else begin
      LMD_q  <= LMD_i;
      ALUo_q <= ALUo_i;
      cond_q <= cond_i;
      IR_q   <= IR_i;
    end
  end

  // cond is carried for pipeline completeness only.
  logic unused_cond;
  assign unused_cond = ^cond_q;

  logic dec_wr, dec_asel, dec_dsel;

  wb_decode #(.DATA_W(DATA_W)) u_dec (
    .ir_i       (IR_q),
    .write_o    (dec_wr),
    .addr_sel_o (dec_asel),
    .data_sel_o (dec_dsel)
  );

  logic [REG_ADDR_W-1:0] dst;
  assign dst = (dec_asel == ASEL_RD) ? IR_q[RD_HI:RD_LO] : IR_q[RT_HI:RT_LO];

  always_comb begin
    WB_Write = dec_wr;
`ifdef WB_R0_GUARD_EN
    if (dst == '0) WB_Write = 1'b0;
`endif
    WB_Addr = '0;
    WB_Data = '0;
    if (WB_Write) begin
      WB_Addr = dst;
      WB_Data = (dec_dsel == DSEL_LMD) ? LMD_q : ALUo_q;
    end
  end

endmodule

// File: tb/tb_wb_seg.sv
module tb_wb_seg;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] LMD_i = '0, ALUo_i = '0, cond_i = '0, IR_i = '0;
  logic [31:0] WB_Data;
  logic        WB_Write;
  logic [4:0]  WB_Addr;

  int vecs = 0;
  int errs = 0;
  exp_t q[$];

  wb_seg dut (
    .clk      (clk),
    .rst      (rst),
    .LMD_i    (LMD_i),
    .ALUo_i   (ALUo_i),
    .cond_i   (cond_i),
    .IR_i     (IR_i),
    .WB_Data  (WB_Data),
    .WB_Write (WB_Write),
    .WB_Addr  (WB_Addr)
  );

  always #5 clk = ~clk;

  // Reference: what the register file should see for one instruction.
  function automatic exp_t model(logic [31:0] ir, logic [31:0] lmd, logic [31:0] alu);
    exp_t e = '0;
    int op = int'(ir[31:26]);
    if (ir == 32'd0) return e;
    if (op == 0) begin
      e.wr = 1'b1; e.addr = ir[15:11]; e.data = alu;
    end else if (op >= 8 && op <= 15) begin
      e.wr = 1'b1; e.addr = ir[20:16]; e.data = alu;
    end else if (op == 35) begin
      e.wr = 1'b1; e.addr = ir[20:16]; e.data = lmd;
    end
`ifdef WB_R0_GUARD_EN
    if (e.wr && e.addr == 5'd0) e = '0;
`endif
    return e;
  endfunction

  task automatic chk(string name, exp_t e);
    vecs++;
    if (WB_Write !== e.wr || WB_Addr !== e.addr || WB_Data !== e.data) begin
      errs++;
      $display("FAIL %s t=%0t: got wr=%b addr=%0d data=%h, want wr=%b addr=%0d data=%h",
               name, $time, WB_Write, WB_Addr, WB_Data, e.wr, e.addr, e.data);
    end
  endtask

  // Monitor: every clock edge (and every reset assertion) produces an output.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (!rst) chk("reset", '0);
      else if (q.size() > 0) chk("pipe", q.pop_front());
    end
  end

  task automatic drive(logic [31:0] ir, logic [31:0] lmd, logic [31:0] alu, logic [31:0] cnd);
    @(negedge clk);
    IR_i = ir; LMD_i = lmd; ALUo_i = alu; cond_i = cnd;
    q.push_back(model(ir, lmd, alu));
  endtask

  int ops[15] = '{0, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43, 4, 5, 2, 42};

  initial begin
    // Reset with arbitrary inputs applied.
    IR_i = 32'h00432020; LMD_i = $urandom; ALUo_i = $urandom; cond_i = $urandom;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    drive(32'h00432020, 32'd123, 32'd456, 32'd0);   // add rd=4
    drive(32'h20050000, 32'd123, 32'd456, 32'd0);   // addi rt=5
    drive(32'h30060000, 32'd123, 32'd456, 32'd0);   // andi rt=6
    drive(32'h8C070000, 32'd123, 32'd456, 32'd0);   // lw rt=7
    drive(32'h00000000, 32'd123, 32'd456, 32'd0);   // nop
    drive(32'h00000000, 32'd123, 32'd456, 32'hFFFFFFFF);
    drive(32'hAC070000, 32'd123, 32'd456, 32'd0);   // sw
    drive(32'hAC070000, 32'd123, 32'd456, 32'hFFFFFFFF);
    drive(32'hA8000000, 32'd123, 32'd456, 32'd0);   // opcode 101010
    drive(32'hA8000000, 32'd123, 32'd456, 32'hFFFFFFFF);
    drive(32'h10220003, 32'd123, 32'd456, 32'd1);   // beq
    drive(32'h08000010, 32'd123, 32'd456, 32'd0);   // j
    drive(32'h20000000, 32'd123, 32'd456, 32'd0);   // addi rt=0
    drive(32'h00002020, 32'd123, 32'd456, 32'd0);   // add rd=4 from r0
    drive(32'h00432020, 32'd123, 32'd456, 32'd0);   // add, then async reset

    @(posedge clk);
    #3 rst = 1'b0;      // monitor checks zeros 1ns later, before any edge
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(32'h8C090000, 32'd77, 32'd88, 32'd0);     // first after release

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ir;
      int sel = $urandom_range(0, 19);
      ir = $urandom;
      if (sel == 0)      ir = 32'd0;
      else if (sel != 1) ir[31:26] = 6'(ops[$urandom_range(0, 14)]);
      drive(ir, $urandom, $urandom, $urandom);
    end

    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
